// File: rtl/half_adder_if.sv
// Operand, result and counter signals of a half_adder instance.
// The master side drives operands and controls; the slave side is the adder.
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             cnt_clr;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] carry_q;
    logic             out_valid;
    logic [CNT_W-1:0] carry_cnt;

    modport master (
        output a, b, in_valid, cnt_clr,
        input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );

    modport slave (
        input  a, b, in_valid, cnt_clr,
        output sum, carry, sum_q, carry_q, out_valid, carry_cnt
    );
endinterface

// File: rtl/half_adder.sv
// Per-lane half adder with combinational and registered results plus a
// saturating counter of accepted cycles in which any lane produced a carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    half_adder_if.slave  bus
);
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] carry_r;
    logic             valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_full;
    logic             cnt_inc;

    // Pure bitwise ops keep lanes independent, so an X stays in its own lane.
    always_comb begin
        sum_c   = bus.a ^ bus.b;
        carry_c = bus.a & bus.b;
    end

    assign cnt_full = &cnt_r;
    assign cnt_inc  = bus.in_valid && (|carry_c) && !cnt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r   <= '0;
            carry_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                sum_r   <= sum_c;
                carry_r <= carry_c;
            end
        end
    end

    // Clear wins over a same-cycle carry event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (bus.cnt_clr) begin
            cnt_r <= '0;
        end else if (cnt_inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.sum       = sum_c;
    assign bus.carry     = carry_c;
    assign bus.sum_q     = sum_r;
    assign bus.carry_q   = carry_r;
    assign bus.out_valid = valid_r;
    assign bus.carry_cnt = cnt_r;
endmodule

// File: tb/tb_half_adder.sv
// Directed checks of half_adder: 1-lane, 8-lane and a 2-bit saturating counter.
module tb_half_adder;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    half_adder_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    half_adder_if #(.WIDTH(8), .CNT_W(16)) if8 ();
    half_adder_if #(.WIDTH(1), .CNT_W(2))  ifs ();

    half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    half_adder #(.WIDTH(8), .CNT_W(16)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    half_adder #(.WIDTH(1), .CNT_W(2))  duts (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic set1(input logic a, input logic b, input logic v, input logic clr);
        @(negedge clk);
        if1.a = a; if1.b = b; if1.in_valid = v; if1.cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        if1.a = 1'b0; if1.b = 1'b0; if1.in_valid = 1'b0; if1.cnt_clr = 1'b0;
        if8.a = 8'h00; if8.b = 8'h00; if8.in_valid = 1'b0; if8.cnt_clr = 1'b0;
        ifs.a = 1'b0; ifs.b = 1'b0; ifs.in_valid = 1'b0; ifs.cnt_clr = 1'b0;
        #1;
        chk("rst_sum_q",   64'(if1.sum_q), 64'd0);
        chk("rst_carry_q", 64'(if1.carry_q), 64'd0);
        chk("rst_valid",   64'(if1.out_valid), 64'd0);
        chk("rst_cnt",     64'(if1.carry_cnt), 64'd0);

        // Truth table, combinational only (registers held in reset).
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [1:0] exp_sc;
            ab = 2'(i);
            exp_sc = (i == 0) ? 2'b00 : (i == 3) ? 2'b01 : 2'b10;
            if1.a = ab[1]; if1.b = ab[0];
            #10;
            chk($sformatf("comb_sum_%0d", i),   64'(if1.sum),   64'(exp_sc[1]));
            chk($sformatf("comb_carry_%0d", i), 64'(if1.carry), 64'(exp_sc[0]));
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Clocked truth table: registered copy one cycle later.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [1:0] exp_sc;
            ab = 2'(i);
            exp_sc = (i == 0) ? 2'b00 : (i == 3) ? 2'b01 : 2'b10;
            set1(ab[1], ab[0], 1'b1, 1'b0);
            tick();
            chk($sformatf("reg_sum_%0d", i),   64'(if1.sum_q),     64'(exp_sc[1]));
            chk($sformatf("reg_carry_%0d", i), 64'(if1.carry_q),   64'(exp_sc[0]));
            chk($sformatf("reg_valid_%0d", i), 64'(if1.out_valid), 64'd1);
        end
        chk("cnt_after_table", 64'(if1.carry_cnt), 64'd1);

        set1(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("cnt_clr_idle", 64'(if1.carry_cnt), 64'd0);
        chk("valid_drop",   64'(if1.out_valid), 64'd0);

        // Hold: invalid carry-producing input must not disturb anything.
        set1(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("hold_sum_q",   64'(if1.sum_q),     64'd1);
        chk("hold_carry_q", 64'(if1.carry_q),   64'd0);
        chk("hold_valid",   64'(if1.out_valid), 64'd0);
        chk("hold_cnt",     64'(if1.carry_cnt), 64'd0);

        for (int i = 0; i < 5; i++) begin
            set1(1'b1, 1'b1, 1'b1, 1'b0);
            tick();
        end
        chk("cnt_five", 64'(if1.carry_cnt), 64'd5);
        chk("carry_q_11", 64'(if1.carry_q), 64'd1);

        set1(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("cnt_clr_prio", 64'(if1.carry_cnt), 64'd0);

        // Saturation on the 2-bit counter.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifs.a = 1'b1; ifs.b = 1'b1; ifs.in_valid = 1'b1;
            tick();
            if (i == 2) chk("sat_reach3", 64'(ifs.carry_cnt), 64'd3);
        end
        chk("sat_hold3", 64'(ifs.carry_cnt), 64'd3);
        @(negedge clk);
        ifs.in_valid = 1'b0;

        // Eight lanes.
        @(negedge clk);
        if8.a = 8'hF0; if8.b = 8'hCC; if8.in_valid = 1'b1;
        #1;
        chk("w8_sum",   64'(if8.sum),   64'h3C);
        chk("w8_carry", 64'(if8.carry), 64'hC0);
        chk("w8_carry_q_pre", 64'(if8.carry_q), 64'h00);
        tick();
        chk("w8_carry_q", 64'(if8.carry_q), 64'hC0);
        chk("w8_sum_q",   64'(if8.sum_q),   64'h3C);
        chk("w8_cnt",     64'(if8.carry_cnt), 64'd1);

        // Mid-stream asynchronous reset between edges.
        set1(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("pre_rst_cnt", 64'(if1.carry_cnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum_q",   64'(if1.sum_q),     64'd0);
        chk("mid_rst_carry_q", 64'(if1.carry_q),   64'd0);
        chk("mid_rst_valid",   64'(if1.out_valid), 64'd0);
        chk("mid_rst_cnt",     64'(if1.carry_cnt), 64'd0);
        chk("mid_rst_w8_cq",   64'(if8.carry_q),   64'h00);
        if1.a = 1'b1; if1.b = 1'b0;
        #1;
        chk("mid_rst_comb_sum",   64'(if1.sum),   64'd1);
        chk("mid_rst_comb_carry", 64'(if1.carry), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
        #1;
        chk("post_rst_pre_edge", 64'(if1.carry_q), 64'd0);
        tick();
        chk("post_rst_carry_q", 64'(if1.carry_q),   64'd1);
        chk("post_rst_sum_q",   64'(if1.sum_q),     64'd0);
        chk("post_rst_valid",   64'(if1.out_valid), 64'd1);
        chk("post_rst_cnt",     64'(if1.carry_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
Single-bit-per-lane half adder with a registered output stage and a carry-event counter. Each lane produces sum = a XOR b and carry = a AND b combinationally. A one-cycle registered copy of the results, qualified by a valid strobe, is also provided. It is a leaf arithmetic primitive used by adder trees and by bit-level checkers that need both immediate and pipelined results.

Parameters:
WIDTH, 1, number of independent half-adder lanes (1..64)
CNT_W, 16, width of the saturating carry-event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
a  in  WIDTH  addend A, one bit per lane
b  in  WIDTH  addend B, one bit per lane
in_valid  in  1  qualifies a/b for the registered stage and the counter
sum  out  WIDTH  combinational a XOR b per lane
carry  out  WIDTH  combinational a AND b per lane
sum_q  out  WIDTH  registered sum
carry_q  out  WIDTH  registered carry
out_valid  out  1  registered in_valid
carry_cnt  out  CNT_W  saturating count of accepted cycles with any carry set
cnt_clr  in  1  synchronous clear of carry_cnt

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path: sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i] for every lane. No dependence on clk, rst_n or in_valid. Zero latency; outputs follow inputs within the same delta.
- Lanes are independent. There is no ripple between lanes.
- Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Registered path: on each rising clk with in_valid=1, sum_q<=sum and carry_q<=carry. With in_valid=0, sum_q and carry_q hold. out_valid<=in_valid every cycle. Latency is 1 cycle.
- Counter: on rising clk, cnt_clr=1 sets carry_cnt to 0. cnt_clr has priority over counting. Otherwise, if in_valid=1 and |carry, carry_cnt increments by 1 and saturates at all-ones (no wrap).
- Reset (rst_n=0, any time including mid-stream): sum_q, carry_q, out_valid and carry_cnt go to 0 immediately. The combinational sum and carry stay functional during reset. On release, the first accepted input appears on sum_q/carry_q one clock later.
- X on an input lane propagates only to that lane's outputs.

Test Plan:
- WIDTH=1, apply {a,b}=0,1,2,3 for 10 ns each -> sum/carry = 0/0, 1/0, 1/0, 0/1 combinationally, with no clock needed.
- Same sequence with in_valid=1 clocked -> sum_q/carry_q match the previous cycle's values and out_valid=1 one cycle after in_valid.
- in_valid=0 while a=b=1 -> sum_q/carry_q hold their old values and carry_cnt is unchanged.
- Counter: 5 accepted cycles with a=b=1 -> carry_cnt=5. cnt_clr=1 together with carry -> carry_cnt=0. With CNT_W=2, 6 carry cycles -> carry_cnt=3 (saturated).
- Assert rst_n=0 between clock edges mid-stream -> registered outputs and carry_cnt are 0 immediately, while sum/carry still track a/b.
- WIDTH=8, a=8'hF0, b=8'hCC -> sum=8'h3C, carry=8'hC0, and carry_q=8'hC0 one cycle later.
